// File: rtl/arp_tx.sv
// ARP transmit engine: snapshots a reply/request job, handshakes with the MAC tx framer and
// streams the ARP payload MSB first. `define ARP_TX_GRATUITOUS_EN adds a gratuitous-ARP source.
module arp_tx #(
  parameter int PAYLOAD_LEN = 46,
  parameter int ACK_TIMEOUT = 1023
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] local_ip_addr,
  input  logic [47:0] local_mac_addr,
  input  logic        arp_reply_req,
  output logic        arp_reply_ack,
  input  logic [31:0] arp_rec_source_ip_addr,
  input  logic [47:0] arp_rec_source_mac_addr,
  input  logic        arp_request_req,
  output logic        arp_request_ack,
  input  logic [31:0] arp_request_ip_addr,
`ifdef ARP_TX_GRATUITOUS_EN
  input  logic        arp_gratuitous_req,
  output logic        arp_gratuitous_ack,
`endif
  output logic        arp_tx_req,
  input  logic        arp_tx_ack,
  output logic [47:0] arp_tx_dst_mac,
  output logic        arp_tx_valid,
  output logic [7:0]  arp_tx_data,
  output logic        arp_tx_end,
  output logic        arp_tx_busy
);

  localparam int CW = 8;
  localparam int WW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST_BYTE = CW'(PAYLOAD_LEN - 1);
  localparam logic [WW-1:0] LAST_WAIT = WW'(ACK_TIMEOUT - 1);
  localparam logic [47:0]   BCAST     = {48{1'b1}};

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT_ACK, ST_SEND, ST_END} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [WW-1:0]   wait_q, wait_d;
  logic [15:0]     op_q, op_d;
  logic [47:0]     smac_q, smac_d, tmac_q, tmac_d, dst_q, dst_d;
  logic [31:0]     sip_q, sip_d, tip_q, tip_d;
  logic            reply_ack_q, reply_ack_d, request_ack_q, request_ack_d;
  logic            capture;
`ifdef ARP_TX_GRATUITOUS_EN
  logic            grat_ack_q, grat_ack_d;
`endif

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path through the case infers a latch.
    state_d       = state_q;
    cnt_d         = cnt_q;
    wait_d        = wait_q;
    op_d          = op_q;
    smac_d        = smac_q;
    sip_d         = sip_q;
    tmac_d        = tmac_q;
    tip_d         = tip_q;
    dst_d         = dst_q;
    reply_ack_d   = 1'b0;
    request_ack_d = 1'b0;
    capture       = 1'b0;
`ifdef ARP_TX_GRATUITOUS_EN
    grat_ack_d    = 1'b0;
`endif
    unique case (state_q)
      ST_IDLE: begin
        cnt_d  = '0;
        wait_d = '0;
        if (arp_reply_req) begin
          capture     = 1'b1;
          op_d        = 16'h0002;
          tmac_d      = arp_rec_source_mac_addr;
          tip_d       = arp_rec_source_ip_addr;
          dst_d       = arp_rec_source_mac_addr;
          reply_ack_d = 1'b1;
        end else if (arp_request_req) begin
          capture       = 1'b1;
          op_d          = 16'h0001;
          tmac_d        = '0;
          tip_d         = arp_request_ip_addr;
          dst_d         = BCAST;
          request_ack_d = 1'b1;
        end
`ifdef ARP_TX_GRATUITOUS_EN
        else if (arp_gratuitous_req) begin
          capture    = 1'b1;
          op_d       = 16'h0001;
          tmac_d     = '0;
          tip_d      = local_ip_addr;
          dst_d      = BCAST;
          grat_ack_d = 1'b1;
        end
`endif
        if (capture) begin
          smac_d  = local_mac_addr;
          sip_d   = local_ip_addr;
          state_d = ST_WAIT_ACK;
        end
      end
      ST_WAIT_ACK: begin
        // A timed-out job is dropped, not retried: its requester was already acked.
        if (arp_tx_ack)               state_d = ST_SEND;
        else if (wait_q == LAST_WAIT) state_d = ST_IDLE;
        else                          wait_d  = wait_q + 1'b1;
      end
      ST_SEND: begin
        if (cnt_q == LAST_BYTE) state_d = ST_END;
        else                    cnt_d   = cnt_q + 1'b1;
      end
      ST_END:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: the snapshot registers are reset too, so dst_mac and data read 0 straight out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      wait_q        <= '0;
      op_q          <= '0;
      smac_q        <= '0;
      sip_q         <= '0;
      tmac_q        <= '0;
      tip_q         <= '0;
      dst_q         <= '0;
      reply_ack_q   <= 1'b0;
      request_ack_q <= 1'b0;
`ifdef ARP_TX_GRATUITOUS_EN
      grat_ack_q    <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking updates so every register samples the pre-edge value of the others.
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      wait_q        <= wait_d;
      op_q          <= op_d;
      smac_q        <= smac_d;
      sip_q         <= sip_d;
      tmac_q        <= tmac_d;
      tip_q         <= tip_d;
      dst_q         <= dst_d;
      reply_ack_q   <= reply_ack_d;
      request_ack_q <= request_ack_d;
`ifdef ARP_TX_GRATUITOUS_EN
      grat_ack_q    <= grat_ack_d;
`endif
    end
  end

  // The 28 ARP bytes as one MSB-first word; shifting by the byte count walks it, pad bytes fall out as 0.
  logic [223:0] frame, frame_sh;
  assign frame    = {16'h0001, 16'h0800, 8'h06, 8'h04, op_q, smac_q, sip_q, tmac_q, tip_q};
  assign frame_sh = frame << {cnt_q, 3'b000};

  assign arp_tx_req      = (state_q == ST_WAIT_ACK);
  assign arp_tx_valid    = (state_q == ST_SEND);
  assign arp_tx_data     = (state_q == ST_SEND) ? frame_sh[223:216] : 8'h00;
  assign arp_tx_end      = (state_q == ST_SEND) && (cnt_q == LAST_BYTE);
  assign arp_tx_busy     = (state_q != ST_IDLE);
  assign arp_tx_dst_mac  = dst_q;
  assign arp_reply_ack   = reply_ack_q;
  assign arp_request_ack = request_ack_q;
`ifdef ARP_TX_GRATUITOUS_EN
  assign arp_gratuitous_ack = grat_ack_q;
`endif

endmodule

// File: tb/tb_arp_tx.sv
// Directed bench for arp_tx: reply/request frames, priority, timeout, snapshot and mid-frame reset.
module tb_arp_tx;

  localparam int PL = 46;
  localparam logic [223:0] REPLY_V =
    224'h0001_0800_0604_0002_000A35010203_C0A80002_112233445566_C0A8000A;
  localparam logic [223:0] REQ_V =
    224'h0001_0800_0604_0001_000A35010203_C0A80002_000000000000_C0A80001;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] local_ip_addr = '0;
  logic [47:0] local_mac_addr = '0;
  logic        arp_reply_req = 1'b0;
  logic        arp_reply_ack;
  logic [31:0] arp_rec_source_ip_addr = '0;
  logic [47:0] arp_rec_source_mac_addr = '0;
  logic        arp_request_req = 1'b0;
  logic        arp_request_ack;
  logic [31:0] arp_request_ip_addr = '0;
  logic        arp_tx_req;
  logic        arp_tx_ack = 1'b0;
  logic [47:0] arp_tx_dst_mac;
  logic        arp_tx_valid;
  logic [7:0]  arp_tx_data;
  logic        arp_tx_end;
  logic        arp_tx_busy;

  always #5 clk = ~clk;

  arp_tx #(.PAYLOAD_LEN(PL), .ACK_TIMEOUT(1023)) dut (
    .clk(clk), .rst_n(rst_n),
    .local_ip_addr(local_ip_addr), .local_mac_addr(local_mac_addr),
    .arp_reply_req(arp_reply_req), .arp_reply_ack(arp_reply_ack),
    .arp_rec_source_ip_addr(arp_rec_source_ip_addr),
    .arp_rec_source_mac_addr(arp_rec_source_mac_addr),
    .arp_request_req(arp_request_req), .arp_request_ack(arp_request_ack),
    .arp_request_ip_addr(arp_request_ip_addr),
    .arp_tx_req(arp_tx_req), .arp_tx_ack(arp_tx_ack), .arp_tx_dst_mac(arp_tx_dst_mac),
    .arp_tx_valid(arp_tx_valid), .arp_tx_data(arp_tx_data), .arp_tx_end(arp_tx_end),
    .arp_tx_busy(arp_tx_busy)
  );

  int          checks = 0;
  int          failures = 0;
  int          reply_acks, request_acks;
  logic [7:0]  got [0:63];
  int          got_n, end_pos;
  logic [47:0] fr_dst;
  bit          req_seen, first_ok, req_drop_ok;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Advance to the next negedge; requesters drop their level on seeing their ack.
  task automatic tick();
    @(negedge clk);
    if (arp_reply_ack)   begin arp_reply_req   = 1'b0; reply_acks++;   end
    if (arp_request_ack) begin arp_request_req = 1'b0; request_acks++; end
  endtask

  task automatic set_fields();
    local_ip_addr           = 32'hC0A80002;
    local_mac_addr          = 48'h000A35010203;
    arp_rec_source_ip_addr  = 32'hC0A8000A;
    arp_rec_source_mac_addr = 48'h112233445566;
    arp_request_ip_addr     = 32'hC0A80001;
  endtask

  // Grants the frame after ack_delay cycles and records the bytes; optionally mutates inputs
  // after byte mut_at-1 or asserts reset while byte abort_at is on the bus.
  task automatic send_frame(input int ack_delay, input int mut_at, input int abort_at);
    req_seen = 0; first_ok = 0; req_drop_ok = 0;
    got_n = 0; end_pos = -1; fr_dst = '0;
    for (int i = 0; i < 20 && !req_seen; i++) begin
      if (arp_tx_req) req_seen = 1;
      else tick();
    end
    if (!req_seen) return;
    fr_dst = arp_tx_dst_mac;
    repeat (ack_delay) tick();
    arp_tx_ack = 1'b1;
    tick();
    arp_tx_ack = 1'b0;
    first_ok    = arp_tx_valid;
    req_drop_ok = !arp_tx_req;
    for (int i = 0; i < 300; i++) begin
      if (!arp_tx_valid) break;
      if (got_n == abort_at) begin
        rst_n = 1'b0;
        #1;
        return;
      end
      if (got_n < 64) got[got_n] = arp_tx_data;
      if (arp_tx_end) end_pos = got_n;
      got_n++;
      if (got_n == mut_at) begin
        arp_rec_source_mac_addr = '0;
        local_ip_addr           = '0;
        local_mac_addr          = '0;
      end
      tick();
    end
  endtask

  // Number of byte positions where the captured frame differs from the expected ARP header + zero pad.
  function automatic int frame_errs(input logic [223:0] ev);
    int e;
    logic [7:0] x;
    e = (got_n != PL) ? 1 : 0;
    for (int k = 0; k < PL; k++) begin
      x = (k < 28) ? ev[223 - 8*k -: 8] : 8'h00;
      if (k >= got_n || got[k] !== x) e++;
    end
    return e;
  endfunction

  task automatic test_reset();
    arp_reply_req = 1'b1;
    #2;
    checks++;
    if ({arp_tx_req, arp_tx_valid, arp_tx_end, arp_tx_busy, arp_reply_ack, arp_request_ack} !== 6'b0) begin
      failures++;
      $display("FAIL reset_ctrl: got %b expected 000000",
               {arp_tx_req, arp_tx_valid, arp_tx_end, arp_tx_busy, arp_reply_ack, arp_request_ack});
    end
    checks++;
    if ({arp_tx_data, arp_tx_dst_mac} !== 56'h0) begin
      failures++;
      $display("FAIL reset_data: got %h/%h expected 0/0", arp_tx_data, arp_tx_dst_mac);
    end
    tick(); tick();
    checks++;
    if ({arp_tx_busy, arp_reply_ack} !== 2'b00) begin
      failures++;
      $display("FAIL reset_hold: busy/ack got %b expected 00", {arp_tx_busy, arp_reply_ack});
    end
    arp_reply_req = 1'b0;
    rst_n = 1'b1;
    tick();
    checks++;
    if (arp_tx_busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_release_busy: got %b expected 0", arp_tx_busy);
    end
  endtask

  task automatic test_reply();
    reply_acks = 0; request_acks = 0;
    set_fields();
    arp_reply_req = 1'b1;
    send_frame(3, -1, -1);
    checks++;
    if ({req_seen, first_ok, req_drop_ok} !== 3'b111) begin
      failures++;
      $display("FAIL reply_handshake: seen/first/drop got %b expected 111", {req_seen, first_ok, req_drop_ok});
    end
    checks++;
    if (fr_dst !== 48'h112233445566) begin
      failures++;
      $display("FAIL reply_dst: got %h expected 112233445566", fr_dst);
    end
    checks++;
    if (frame_errs(REPLY_V) !== 0) begin
      failures++;
      $display("FAIL reply_bytes: %0d bad bytes of %0d received, expected 0 bad of 46", frame_errs(REPLY_V), got_n);
    end
    checks++;
    if (end_pos !== 45) begin
      failures++;
      $display("FAIL reply_end: got byte %0d expected 45", end_pos);
    end
    checks++;
    if ({reply_acks, request_acks} !== {32'd1, 32'd0}) begin
      failures++;
      $display("FAIL reply_acks: got %0d/%0d expected 1/0", reply_acks, request_acks);
    end
    checks++;
    if ({arp_tx_busy, arp_tx_valid} !== 2'b10) begin
      failures++;
      $display("FAIL reply_end_state: busy/valid got %b expected 10", {arp_tx_busy, arp_tx_valid});
    end
    tick();
    checks++;
    if (arp_tx_busy !== 1'b0) begin
      failures++;
      $display("FAIL reply_idle: busy got %b expected 0", arp_tx_busy);
    end
  endtask

  task automatic test_request();
    reply_acks = 0; request_acks = 0;
    arp_request_req = 1'b1;
    send_frame(0, -1, -1);
    checks++;
    if (fr_dst !== 48'hFFFFFFFFFFFF) begin
      failures++;
      $display("FAIL request_dst: got %h expected ffffffffffff", fr_dst);
    end
    checks++;
    if (frame_errs(REQ_V) !== 0 || end_pos !== 45) begin
      failures++;
      $display("FAIL request_bytes: %0d bad bytes, end at %0d, expected 0 bad, end at 45", frame_errs(REQ_V), end_pos);
    end
    checks++;
    if ({reply_acks, request_acks} !== {32'd0, 32'd1}) begin
      failures++;
      $display("FAIL request_acks: got %0d/%0d expected 0/1", reply_acks, request_acks);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    reply_acks = 0; request_acks = 0;
    arp_reply_req   = 1'b1;
    arp_request_req = 1'b1;
    send_frame(1, -1, -1);
    checks++;
    if (fr_dst !== 48'h112233445566 || frame_errs(REPLY_V) !== 0) begin
      failures++;
      $display("FAIL b2b_first: dst %h with %0d bad bytes, expected reply to 112233445566 with 0 bad", fr_dst, frame_errs(REPLY_V));
    end
    checks++;
    if ({reply_acks, request_acks} !== {32'd1, 32'd0}) begin
      failures++;
      $display("FAIL b2b_acks_mid: got %0d/%0d expected 1/0", reply_acks, request_acks);
    end
    send_frame(2, -1, -1);
    checks++;
    if (fr_dst !== 48'hFFFFFFFFFFFF || frame_errs(REQ_V) !== 0) begin
      failures++;
      $display("FAIL b2b_second: dst %h with %0d bad bytes, expected broadcast request with 0 bad", fr_dst, frame_errs(REQ_V));
    end
    tick(); tick();
    checks++;
    if ({reply_acks, request_acks} !== {32'd1, 32'd1} || arp_tx_busy !== 1'b0) begin
      failures++;
      $display("FAIL b2b_acks_end: acks %0d/%0d busy %b expected 1/1 busy 0", reply_acks, request_acks, arp_tx_busy);
    end
  endtask

  task automatic test_timeout();
    int  n;
    bit  seen, saw_valid;
    reply_acks = 0; request_acks = 0;
    n = 0; seen = 0; saw_valid = 0;
    arp_request_req = 1'b1;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (arp_tx_req) seen = 1;
      else tick();
    end
    while (arp_tx_req && n < 1100) begin
      n++;
      if (arp_tx_valid) saw_valid = 1;
      tick();
    end
    checks++;
    if (n !== 1023) begin
      failures++;
      $display("FAIL timeout_req_cycles: got %0d expected 1023", n);
    end
    repeat (5) begin
      if (arp_tx_valid || arp_tx_req) saw_valid = 1;
      tick();
    end
    checks++;
    if ({saw_valid, arp_tx_busy} !== 2'b00) begin
      failures++;
      $display("FAIL timeout_idle: valid_seen/busy got %b expected 00", {saw_valid, arp_tx_busy});
    end
    checks++;
    if (request_acks !== 1) begin
      failures++;
      $display("FAIL timeout_ack: got %0d expected 1", request_acks);
    end
  endtask

  task automatic test_ack_ignored();
    arp_tx_ack = 1'b1;
    tick(); tick(); tick();
    arp_tx_ack = 1'b0;
    checks++;
    if ({arp_tx_busy, arp_tx_valid, arp_tx_req} !== 3'b000) begin
      failures++;
      $display("FAIL stray_ack: busy/valid/req got %b expected 000", {arp_tx_busy, arp_tx_valid, arp_tx_req});
    end
  endtask

  task automatic test_snapshot();
    set_fields();
    arp_reply_req = 1'b1;
    send_frame(2, 10, -1);
    checks++;
    if (frame_errs(REPLY_V) !== 0) begin
      failures++;
      $display("FAIL snapshot_bytes: %0d bad bytes expected 0", frame_errs(REPLY_V));
    end
    checks++;
    if (arp_tx_dst_mac !== 48'h112233445566) begin
      failures++;
      $display("FAIL snapshot_dst: got %h expected 112233445566", arp_tx_dst_mac);
    end
    set_fields();
    tick();
  endtask

  task automatic test_reset_mid_frame();
    reply_acks = 0; request_acks = 0;
    arp_reply_req = 1'b1;
    send_frame(1, -1, 20);
    checks++;
    if (got_n !== 20 || end_pos !== -1) begin
      failures++;
      $display("FAIL abort_progress: bytes %0d end %0d expected 20 and -1", got_n, end_pos);
    end
    checks++;
    if ({arp_tx_valid, arp_tx_end, arp_tx_req, arp_tx_busy} !== 4'b0000) begin
      failures++;
      $display("FAIL abort_outputs: valid/end/req/busy got %b expected 0000",
               {arp_tx_valid, arp_tx_end, arp_tx_req, arp_tx_busy});
    end
    tick();
    rst_n = 1'b1;
    reply_acks = 0;
    arp_reply_req = 1'b1;
    send_frame(2, -1, -1);
    checks++;
    if (frame_errs(REPLY_V) !== 0 || end_pos !== 45 || reply_acks !== 1) begin
      failures++;
      $display("FAIL abort_recover: %0d bad bytes, end %0d, acks %0d expected 0, 45, 1", frame_errs(REPLY_V), end_pos, reply_acks);
    end
    tick();
  endtask

  initial begin
    reply_acks = 0;
    request_acks = 0;
    test_reset();
    test_reply();
    test_request();
    test_back_to_back();
    test_timeout();
    test_ack_ignored();
    test_snapshot();
    test_reset_mid_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
